// File: rtl/arith_scheduler.sv
// Round-robin front end for the shared signed arithmetic unit: two valid/ready requesters, one tagged response each.
// Latency: response 3 cycles after accept (1 cycle if rejected); response held until rsp_ready, no accepts meanwhile.
module arith_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [3:0]         req0_fun,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [3:0]         req1_fun,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_fun,
    output logic               arith_en,
    input  logic [2*WIDTH-1:0] alu_result,
    input  logic               alu_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             last_gnt;
    logic             gnt_id;
    logic             accept;
    logic             reject;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_fun;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt_id     = req1_valid && (!req0_valid || !last_gnt);
        accept     = (state == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sel_a      = gnt_id ? req1_a   : req0_a;
        sel_b      = gnt_id ? req1_b   : req0_b;
        sel_fun    = gnt_id ? req1_fun : req0_fun;
        reject     = (sel_fun > 4'd3) || ((sel_fun == 4'd3) && (sel_b == '0));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            arith_en  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_gnt <= gnt_id;
                        rsp_id   <= gnt_id;
                        // Illegal operations bypass the unit entirely.
                        if (reject) begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_fun  <= sel_fun;
                            arith_en <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_a    <= '0;
                    alu_b    <= '0;
                    alu_fun  <= '0;
                    arith_en <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    rsp_data  <= alu_result;
                    rsp_err   <= !alu_flag;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/arith_scheduler.md
# arith_scheduler

Two-requester round-robin scheduler for the shared signed arithmetic unit. It accepts operation requests from two independent clients over valid/ready handshakes, one at a time. It drives the arithmetic unit's operand, function and enable inputs, and collects the unit's registered result and flag. It returns one tagged response per request and traps division by zero and unsupported function codes, so the arithmetic unit never sees them.

## Interface
- WIDTH, 16, operand width; results are 2*WIDTH bits signed
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  signed operands
- req0_fun / req1_fun  in  4  function code: 0 add, 1 sub, 2 mul, 3 div
- alu_a, alu_b  out  WIDTH  operands to arithmetic unit
- alu_fun  out  4  function to arithmetic unit
- arith_en  out  1  arithmetic unit enable
- alu_result  in  2*WIDTH  registered result from arithmetic unit
- alu_flag  in  1  registered valid flag from arithmetic unit
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  2*WIDTH  signed result; 0 on error
- rsp_id  out  1  requester index (0/1)
- rsp_err  out  1  operation rejected or unit flag missing
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any reqN_valid, grant one requester.
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not granted last. The last-grant pointer resets to 1, so req0 wins the first tie.
  - reqN_ready = 1 combinationally for the granted requester only, in IDLE only.
  - On the handshake, capture a, b, fun and id into registers and update the last-grant pointer.
- Rejection check at capture: fun > 3, or fun == 3 with b == 0.
  - On rejection, go to RESP with rsp_err=1, rsp_data=0. The ISSUE and WAIT states are skipped and arith_en is never asserted.
  - Otherwise go to ISSUE.
- ISSUE: arith_en=1 and alu_a/alu_b/alu_fun = captured values. All four are registered outputs, valid for this single cycle. Next state is WAIT.
- WAIT: arith_en=0. alu_result/alu_flag reflect the issued operation.
  - Register rsp_data=alu_result and rsp_err=!alu_flag.
  - Next state is RESP.
- RESP: rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable until rsp_valid && rsp_ready, then go to IDLE. No new request is accepted while in RESP.
- Outside ISSUE: arith_en=0, and alu_a/alu_b/alu_fun are driven to 0.
- Arithmetic is performed by the unit only. The scheduler does not modify the result: the full 2*WIDTH signed value is passed through, and division truncates toward zero as the unit does.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE and the last-grant pointer goes to 1.
  - req0_ready, req1_ready, arith_en, rsp_valid, rsp_err, rsp_id and busy = 0.
  - alu_a, alu_b, alu_fun and rsp_data = 0.
  - An in-flight operation is discarded with no response.
- Normal path: handshake at cycle 0, arith_en high in cycle 1, result registered at the end of cycle 2, rsp_valid high from cycle 3.
- Rejected path: handshake at cycle 0, rsp_valid high from cycle 1.
- Back-to-back throughput is one accepted request per 4 cycles when rsp_ready is held at 1. The next handshake can occur in the cycle after the response handshake.
- A request still valid while its requester is not granted waits with ready=0. Its inputs must be held stable by the requester.
- If rsp_ready is already 1 when rsp_valid rises, the response completes in that same cycle.

## Test plan
- Single add: req0 a=7, b=5, fun=0 -> arith_en pulses in cycle 1 with alu_a=7, alu_b=5; in cycle 3 rsp_valid=1, rsp_data=12, rsp_id=0, rsp_err=0.
- Signed multiply/divide: req1 a=-300, b=200, fun=2 -> rsp_data=-60000, rsp_id=1. Then a=-7, b=2, fun=3 -> rsp_data=-3.
- Arbitration: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 across four responses, with rsp_id matching. The first grant after reset goes to req0.
- Rejection: req0 a=9, b=0, fun=3 -> arith_en never asserted; in cycle 1 rsp_err=1, rsp_data=0. Then fun=4'b0101 -> same rejection response.
- Backpressure: rsp_ready held 0 for 5 cycles during RESP -> rsp_valid/rsp_data/rsp_id stay stable and both ready outputs stay 0. Releasing rsp_ready completes the response; the next request is accepted one cycle later.
- Reset mid-operation: assert rst during WAIT -> all outputs 0 immediately and no response produced. After release, a pending req0 and req1 tie grants req0.
